uart_matrix_router: RTL and testbench



---
 rtl/uart_matrix_router.sv | 107 ++++++++++
 tb/tb_uart_matrix_router.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matrix_router.sv
// uart_matrix_router: N_RX 8N1 receivers feeding a shared byte bus,
// with per-destination strobes taken from a writable routing table.
module uart_matrix_router #(
    parameter int N_RX = 2,
    parameter int N_TX = 3,
    parameter logic [N_RX*N_TX-1:0] LUT_INIT = {3'b001, 3'b111}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_RX-1:0]           rx,
    input  logic [N_TX-1:0]           lut_data,
    input  logic [$clog2(N_RX+1)-1:0] lut_addr,
    input  logic                      lut_cke,
    output logic [7:0]                tx,
    output logic [N_TX-1:0]           tx_cke,
    output logic                      clko
);

    localparam int AW = $clog2(N_RX + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } rx_state_t;

    rx_state_t            st   [N_RX];
    logic [2:0]           cnt  [N_RX];
    logic [7:0]           shf  [N_RX];
    logic [7:0]           hold [N_RX];
    logic [N_RX-1:0]      pend;
    logic [N_RX*N_TX-1:0] lut;

    logic                 gnt_vld;
    logic [AW-1:0]        gnt_idx;
    logic [7:0]           gnt_byte;
    logic [N_TX-1:0]      gnt_mask;

    assign clko = ~clk;

    // Walk downward so the lowest pending index is the one that sticks.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_byte = '0;
        gnt_mask = '0;
        for (int i = N_RX - 1; i >= 0; i--) begin
            if (pend[i]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = AW'(i);
                gnt_byte = hold[i];
                gnt_mask = lut[i*N_TX +: N_TX];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx     <= '0;
            tx_cke <= '0;
            pend   <= '0;
            lut    <= LUT_INIT;
            for (int i = 0; i < N_RX; i++) begin
                st[i]   <= IDLE;
                cnt[i]  <= '0;
                shf[i]  <= '0;
                hold[i] <= '0;
            end
        end else begin
            tx_cke <= '0;
            if (gnt_vld) begin
                tx     <= gnt_byte;
                tx_cke <= gnt_mask;
            end
            for (int i = 0; i < N_RX; i++) begin
                if (lut_cke && lut_addr == AW'(i))
                    lut[i*N_TX +: N_TX] <= lut_data;
                if (gnt_vld && gnt_idx == AW'(i))
                    pend[i] <= 1'b0;
                unique case (st[i])
                    IDLE: begin
                        if (!rx[i]) begin
                            st[i]  <= DATA;
                            cnt[i] <= '0;
                        end
                    end
                    DATA: begin
                        shf[i] <= {rx[i], shf[i][7:1]};
                        cnt[i] <= cnt[i] + 3'd1;
                        if (cnt[i] == 3'd7)
                            st[i] <= STOP;
                    end
                    STOP: begin
                        st[i] <= IDLE;
                        // A fresh byte wins over a same-edge grant clear.
                        if (rx[i]) begin
                            hold[i] <= shf[i];
                            pend[i] <= 1'b1;
                        end
                    end
                    default: st[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_matrix_router.sv
// Directed bench for uart_matrix_router: frames driven on negedge,
// strobes logged on negedge and compared with hand-computed values.
module tb_uart_matrix_router;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rx;
    logic [2:0] lut_data;
    logic [1:0] lut_addr;
    logic       lut_cke;
    logic [7:0] tx;
    logic [2:0] tx_cke;
    logic       clko;

    uart_matrix_router dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .lut_data (lut_data),
        .lut_addr (lut_addr),
        .lut_cke  (lut_cke),
        .tx       (tx),
        .tx_cke   (tx_cke),
        .clko     (clko)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic [2:0] m;
        int         c;
    } disp_t;

    disp_t dq[$];
    int    cyc = 0;
    int    rst_strobes = 0;
    int    total = 0;
    int    bad = 0;
    int    s;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_cke != 3'b000) begin
            dq.push_back('{b: tx, m: tx_cke, c: cyc});
            if (!rst_n) rst_strobes++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just before the dispatch edge S+10.
    task automatic frames(input logic [1:0] en,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic st0, input logic st1,
                          output int start);
        @(negedge clk);
        start = cyc + 1;
        rx = ~en;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rx[0] = en[0] ? b0[k] : 1'b1;
            rx[1] = en[1] ? b1[k] : 1'b1;
        end
        @(negedge clk);
        rx[0] = en[0] ? st0 : 1'b1;
        rx[1] = en[1] ? st1 : 1'b1;
        @(negedge clk);
        rx = 2'b11;
    endtask

    task automatic lut_wr(input logic [1:0] a, input logic [2:0] d);
        @(negedge clk);
        lut_addr = a;
        lut_data = d;
        lut_cke  = 1'b1;
        @(negedge clk);
        lut_cke  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rx = 2'b11;
        lut_data = '0;
        lut_addr = '0;
        lut_cke = 1'b0;
        idle(3);
        chk("rst_tx", int'(tx), 'h00);
        chk("rst_cke", int'(tx_cke), 0);
        chk("clko", int'(clko), 1);
        rst_n = 1'b1;
        idle(2);

        // 1: default mask, latency 10 from start edge
        frames(2'b01, 8'h33, 8'h00, 1'b1, 1'b1, s);
        idle(4);
        chk("t1_n", dq.size(), 1);
        if (dq.size() >= 1) begin
            chk("t1_tx", int'(dq[0].b), 'h33);
            chk("t1_cke", int'(dq[0].m), 'b111);
            chk("t1_lat", dq[0].c - s, 10);
        end
        chk("t1_hold", int'(tx), 'h33);
        chk("t1_idle", int'(tx_cke), 0);
        dq.delete();

        // 2: rewritten mask for rx0
        lut_wr(2'd0, 3'b101);
        frames(2'b01, 8'h33, 8'h00, 1'b1, 1'b1, s);
        idle(4);
        chk("t2_n", dq.size(), 1);
        if (dq.size() >= 1) begin
            chk("t2_tx", int'(dq[0].b), 'h33);
            chk("t2_cke", int'(dq[0].m), 'b101);
        end
        dq.delete();

        // 3: simultaneous frames, rx0 first then rx1
        frames(2'b11, 8'h33, 8'hCC, 1'b1, 1'b1, s);
        idle(4);
        chk("t3_n", dq.size(), 2);
        if (dq.size() >= 2) begin
            chk("t3_tx0", int'(dq[0].b), 'h33);
            chk("t3_cke0", int'(dq[0].m), 'b101);
            chk("t3_lat0", dq[0].c - s, 10);
            chk("t3_tx1", int'(dq[1].b), 'hCC);
            chk("t3_cke1", int'(dq[1].m), 'b001);
            chk("t3_lat1", dq[1].c - s, 11);
        end
        dq.delete();

        // 4: framing error dropped, next frame fine
        frames(2'b10, 8'h00, 8'h77, 1'b1, 1'b0, s);
        idle(4);
        chk("t4_ferr", dq.size(), 0);
        frames(2'b10, 8'h00, 8'h5C, 1'b1, 1'b1, s);
        idle(4);
        chk("t4_n", dq.size(), 1);
        if (dq.size() >= 1) begin
            chk("t4_tx", int'(dq[0].b), 'h5C);
            chk("t4_cke", int'(dq[0].m), 'b001);
        end
        dq.delete();

        // 5: new rx1 mask; out-of-range address ignored
        lut_wr(2'd1, 3'b011);
        frames(2'b10, 8'h00, 8'hA5, 1'b1, 1'b1, s);
        idle(4);
        lut_wr(2'd3, 3'b110);
        frames(2'b11, 8'h3C, 8'hA5, 1'b1, 1'b1, s);
        idle(4);
        chk("t5_n", dq.size(), 3);
        if (dq.size() >= 3) begin
            chk("t5_tx", int'(dq[0].b), 'hA5);
            chk("t5_cke", int'(dq[0].m), 'b011);
            chk("t5_a3_0", int'(dq[1].m), 'b101);
            chk("t5_tx1", int'(dq[1].b), 'h3C);
            chk("t5_a3_1", int'(dq[2].m), 'b011);
        end
        dq.delete();

        // write on the dispatch edge: old mask used, new mask next time
        frames(2'b01, 8'h81, 8'h00, 1'b1, 1'b1, s);
        lut_addr = 2'd0;
        lut_data = 3'b010;
        lut_cke  = 1'b1;
        @(negedge clk);
        lut_cke  = 1'b0;
        idle(3);
        frames(2'b01, 8'h18, 8'h00, 1'b1, 1'b1, s);
        idle(4);
        chk("wr_n", dq.size(), 2);
        if (dq.size() >= 2) begin
            chk("wr_old", int'(dq[0].m), 'b101);
            chk("wr_new", int'(dq[1].m), 'b010);
        end
        dq.delete();

        // zero mask drops the byte
        lut_wr(2'd0, 3'b000);
        frames(2'b01, 8'h99, 8'h00, 1'b1, 1'b1, s);
        idle(4);
        chk("zero_n", dq.size(), 0);

        // 6: reset mid-frame
        @(negedge clk);
        rx[0] = 1'b0;
        idle(1);
        rx[0] = 1'b1;
        idle(3);
        rst_n = 1'b0;
        idle(1);
        chk("t6_rtx", int'(tx), 'h00);
        idle(11);
        rst_n = 1'b1;
        idle(2);
        frames(2'b01, 8'h5A, 8'h00, 1'b1, 1'b1, s);
        idle(12);
        chk("t6_rcke", rst_strobes, 0);
        chk("t6_n", dq.size(), 1);
        if (dq.size() >= 1) begin
            chk("t6_tx", int'(dq[0].b), 'h5A);
            chk("t6_cke", int'(dq[0].m), 'b111);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
